// File: rtl/sr_ff_driver.sv
// Handshaked driver for an external SR flip-flop: pulses S or R toward a requested state,
// waits a settle window, then checks the fed-back outputs. Optional: SR_FF_DRIVER_QN_CHECK_EN.
module sr_ff_driver #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned ERR_CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   input  logic                 req_q,
   output logic                 req_ready,
   input  logic                 q_fb,
   input  logic                 qn_fb,
   output logic                 s,
   output logic                 r,
   output logic                 busy,
   output logic                 done,
   output logic                 mismatch,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   typedef enum logic [1:0] {StIdle, StDrive, StSettle, StDone} state_e;

   state_e               state_q;
   logic                 tgt_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 s_q;
   logic                 r_q;
   logic                 ready_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 mism_q;
   logic [ERR_CNT_W-1:0] err_q;
   logic                 fail;

`ifdef SR_FF_DRIVER_QN_CHECK_EN
   always_comb begin
      fail = (q_fb != tgt_q) || (qn_fb != !tgt_q);
   end
`else
   logic unused_qn_fb;
   assign unused_qn_fb = qn_fb;

   always_comb begin
      fail = (q_fb != tgt_q);
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         tgt_q   <= 1'b0;
         cnt_q   <= '0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mism_q  <= 1'b0;
         err_q   <= '0;
      end else begin
         // Pulse-type outputs default low; only the state that owns them raises them.
         s_q    <= 1'b0;
         r_q    <= 1'b0;
         done_q <= 1'b0;
         mism_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  tgt_q   <= req_q;
                  // Excitation from the state seen at acceptance; equal states mean hold.
                  s_q     <= req_q & ~q_fb;
                  r_q     <= ~req_q & q_fb;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= StDrive;
               end
            end
            StDrive: begin
               cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
               state_q <= StSettle;
            end
            StSettle: begin
               if (cnt_q == '0) begin
                  done_q  <= 1'b1;
                  mism_q  <= fail;
                  if (fail && (err_q != ERR_MAX)) begin
                     err_q <= err_q + ERR_CNT_W'(1);
                  end
                  state_q <= StDone;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            StDone: begin
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign s         = s_q;
   assign r         = r_q;
   assign req_ready = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign mismatch  = mism_q;
   assign err_cnt   = err_q;

endmodule

// File: doc/sr_ff_driver.md
# sr_ff_driver

Sequential controller that drives an external SR flip-flop (for example `sr_ff_using_t_ff`) from a stream of requested target states. For each request it derives S/R excitation from the current fed-back `q`, pulses `s` or `r` for one cycle, waits a settle window, reads `q`/`qn` back and reports pass/fail. It acts as the transmitting end of the flip-flop's S/R interface and replaces hand-written stimulus tasks with a self-checking, handshaked driver.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1, idle cycles between the drive cycle and the feedback sample; legal range is 1 or more.
- `ERR_CNT_W`, default 8, width of the error counter.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset. Synchronous and active-low: `rst`=0 at a rising edge resets the block.
- `req_valid`  in  1  request present.
- `req_q`  in  1  requested target state.
- `req_ready`  out  1  block can accept a request.
- `q_fb`  in  1  `q` fed back from the flip-flop.
- `qn_fb`  in  1  `qn` fed back from the flip-flop.
- `s`  out  1  set excitation, registered.
- `r`  out  1  reset excitation, registered.
- `busy`  out  1  a request is in progress.
- `done`  out  1  one-cycle completion pulse.
- `mismatch`  out  1  fail flag; valid only while `done`=1, otherwise 0.
- `err_cnt`  out  ERR_CNT_W  saturating count of failed requests.

## Operation
- FSM states: IDLE, DRIVE, SETTLE, DONE.
- **IDLE**
  - `req_ready`=1, `busy`=0, `s`=`r`=0.
  - On `req_valid && req_ready`: capture `req_q` into `tgt` and `q_fb` into `q_start`, then go to DRIVE.
- **DRIVE**, exactly 1 cycle. Excitation:
  - `q_start`=0 and `tgt`=1: `s`=1, `r`=0.
  - `q_start`=1 and `tgt`=0: `s`=0, `r`=1.
  - `q_start`=`tgt`: `s`=`r`=0 (hold). The request still runs through SETTLE and DONE.
  - Then go to SETTLE and load the settle counter with `SETTLE_CYCLES`-1.
- **SETTLE**
  - `s`=`r`=0.
  - The counter decrements each cycle.
  - At the edge that ends the last SETTLE cycle, sample `q_fb` and `qn_fb` into the result registers, compute fail, update `err_cnt`, then go to DONE.
- **DONE**, exactly 1 cycle.
  - `done`=1.
  - `mismatch`=fail, where fail = (sampled `q` ≠ `tgt`), optionally OR the qn check (see Configuration).
  - Then go to IDLE.
- `err_cnt` increments by 1 on each fail and saturates at 2^ERR_CNT_W−1. It never wraps.
- Invariant: `s` and `r` are never both 1, in any state or during reset.
- `req_q` and `req_valid` are ignored while `busy`=1.

## Timing
- Reset values: `s`=0, `r`=0, `req_ready`=1, `busy`=0, `done`=0, `mismatch`=0, `err_cnt`=0, state IDLE.
- While `rst`=0 is held, outputs keep their reset values.
- `req_ready`=1 in the cycle after the first edge with `rst`=1.
- Cycle numbering from acceptance edge E0:
  - DRIVE occupies cycle 1.
  - SETTLE occupies cycles 2 to 1+SETTLE_CYCLES.
  - DONE occupies cycle 2+SETTLE_CYCLES.
  - IDLE (`req_ready`=1) starts at cycle 3+SETTLE_CYCLES.
- Throughput: with `req_valid` held high, one request is accepted every SETTLE_CYCLES+3 cycles.
- `busy`=1 from DRIVE through DONE inclusive; `req_ready` = !`busy`.
- Reset mid-operation, in any of DRIVE, SETTLE or DONE:
  - The next cycle is IDLE with `s`=`r`=0.
  - No `done` pulse is produced.
  - `err_cnt` is cleared.
- A fail occurring with `err_cnt` already at maximum: `mismatch`=1, `err_cnt` stays at maximum.

## Configuration
- Macro: `SR_FF_DRIVER_QN_CHECK_EN`.
  - Defined: fail = (`q` ≠ `tgt`) OR (`qn` ≠ !`tgt`), so an invalid complementary output also counts as a mismatch.
  - Undefined: `qn_fb` is ignored. The port remains present and fail = (`q` ≠ `tgt`).

## Test plan
All scenarios use SETTLE_CYCLES=1 and ERR_CNT_W=8 unless noted. Cycle numbers count from the acceptance edge.
1. Hold `rst`=0 for 2 cycles while `req_valid`=1 -> `s`=`r`=`done`=0, `err_cnt`=0, nothing accepted. After release, `req_ready`=1.
2. Behavioural SR model starting at `q`=0; request `req_q`=1 -> `s`=1 in cycle 1 only, `r`=0 throughout. `done`=1 in cycle 3 with `mismatch`=0. `req_ready`=1 in cycle 4.
3. Model at `q`=1; request `req_q`=0 -> `r`=1 in cycle 1 only. `done` in cycle 3 with `mismatch`=0. Repeat with SETTLE_CYCLES=4: `done` in cycle 6.
4. Model at `q`=1; request `req_q`=1 (hold) -> `s`=`r`=0 in every cycle, `done` in cycle 3, `mismatch`=0, `err_cnt` unchanged.
5. `q_fb` stuck at 0; 300 back-to-back requests with `req_q`=1 -> `mismatch`=1 on every `done`, `err_cnt` climbs and holds at 255. With the macro defined, a correct `q_fb` but wrong `qn_fb` also gives `mismatch`=1.
6. Assert `rst`=0 during the SETTLE cycle -> no `done` pulse, `s`=`r`=0, `err_cnt`=0. The next request completes normally.
